// File: rtl/decim_filter_sequencer.sv
// decim_filter_sequencer: drives the decimation core strobes from latched config and
// returns one captured result per group of N samples on a valid/ready stream.
module decim_filter_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEC_WIDTH  = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [DEC_WIDTH-1:0]  cfg_decim,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  core_clr,
    output logic                  core_en,
    output logic                  core_dump,
    input  logic [DATA_WIDTH-1:0] core_result,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg,
    output logic [LEN_WIDTH-1:0]  out_cnt
);
    localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, RUN = 3'd2, CAPT = 3'd3, HOLD = 3'd4, DONE = 3'd5;
    logic [2:0]            state_q, state_d;
    logic [DEC_WIDTH-1:0]  n_q, n_d, ph_q, ph_d;
    logic [LEN_WIDTH-1:0]  l_q, l_d, out_cnt_q, out_cnt_d, out_inc;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  abort_hit, last;
    // abort overrides everything outside IDLE; reset also masks the core strobes
    assign abort_hit = cfg_abort && state_q != IDLE;
    assign s_ready   = S_AXI_ARESETN && state_q == RUN && !abort_hit;
    assign core_en   = s_valid && s_ready;
    assign last      = ph_q == n_q - 1'b1;
    assign core_dump = core_en && last;
    assign core_clr  = S_AXI_ARESETN && (state_q == CLEAR || abort_hit);
    assign out_inc   = out_cnt_q + 1'b1;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cfg   = err_q;
    assign out_cnt   = out_cnt_q;
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        l_d       = l_q;
        ph_d      = ph_q;
        out_cnt_d = out_cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        if (abort_hit) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            busy_d    = 1'b0;
            ph_d      = '0;
        end else begin
            case (state_q)
                IDLE: if (cfg_start) begin
                    if (cfg_decim != '0 && cfg_len != '0) begin
                        n_d     = cfg_decim;
                        l_d     = cfg_len;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = CLEAR;
                    end else err_d = 1'b1;
                end
                CLEAR: begin
                    ph_d      = '0;
                    out_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
                RUN: if (core_en) begin
                    ph_d    = last ? '0 : ph_q + 1'b1;
                    state_d = last ? CAPT : RUN;
                end
                CAPT: begin
                    m_data_d  = core_result;
                    m_valid_d = 1'b1;
                    state_d   = HOLD;
                end
                HOLD: if (m_ready) begin
                    m_valid_d = 1'b0;
                    out_cnt_d = out_cnt_q == l_q ? out_cnt_q : out_inc;
                    state_d   = out_inc == l_q ? DONE : RUN;
                end
                DONE: begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= IDLE;
            n_q       <= '0;
            l_q       <= '0;
            ph_q      <= '0;
            out_cnt_q <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            l_q       <= l_d;
            ph_q      <= ph_d;
            out_cnt_q <= out_cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
endmodule
